// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared bus widths, chip-enable levels and fetch constants
package inst_fetch_pkg;
    localparam int InstAddrBus = 32;
    localparam int InstBus = 64;
    localparam logic ChipEnable = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic [InstBus-1:0] ZeroDoubleWord = '0;
    localparam int PcStep = 8;
    localparam logic [InstAddrBus-1:0] ResetPc = '0;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: ROM, decode handshake and branch-redirect signals of the fetch stage
interface inst_fetch_if import inst_fetch_pkg::*; #(
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus
);
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_inst_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [INST_W-1:0] id_inst_o;
    logic [ADDR_W-1:0] id_pc_o;
    modport master (
        input  branch_flag_i, branch_target_i, rom_inst_i, id_ready_i,
        output rom_ce_o, rom_addr_o, id_valid_o, id_inst_o, id_pc_o
    );
    modport slave (
        output branch_flag_i, branch_target_i, rom_inst_i, id_ready_i,
        input  rom_ce_o, rom_addr_o, id_valid_o, id_inst_o, id_pc_o
    );
endinterface

// File: rtl/inst_fetch_buf.sv
// fetch_buf: DEPTH-entry synchronous FIFO; flush is applied after pop and beats push
module fetch_buf #(
    parameter int W = 96,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [W-1:0]           i_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [W-1:0]           o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    always_ff @(posedge clk) begin
        if (rst | i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
            r_count <= '0;
        end else begin
            r_wr <= i_push ? r_wr + PW'(1) : r_wr;
            r_rd <= i_pop ? r_rd + PW'(1) : r_rd;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push & ~i_flush) r_mem[r_wr] <= i_data;
    end
    assign o_count = r_count;
    assign o_head = r_mem[r_rd];
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC/chip-enable control feeding a small fetch buffer toward decode
module inst_fetch import inst_fetch_pkg::*; #(
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus,
    parameter int DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ResetPc),
    parameter int PC_STEP = PcStep
) (
    input logic clk,
    input logic rst,
    inst_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              r_ce;
    logic [ADDR_W-1:0] r_pc;
    logic [CW-1:0]     w_count;
    logic              w_valid;
    logic              w_pop;
    logic              w_space;
    logic              w_fire;
    assign w_valid = (w_count != '0);
    assign w_pop = w_valid & bus.id_ready_i;
    assign w_space = (w_count < CW'(DEPTH)) | w_pop;
    assign w_fire = r_ce & w_space & ~bus.branch_flag_i;
    fetch_buf #(.W(ADDR_W + INST_W), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fire),
        .i_pop   (w_pop),
        .i_flush (bus.branch_flag_i),
        .i_data  ({r_pc, bus.rom_inst_i}),
        .o_count (w_count),
        .o_head  ({bus.id_pc_o, bus.id_inst_o})
    );
    // A stalled fetch simply re-reads the same ROM address next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ce <= ChipDisable;
            r_pc <= RESET_PC;
        end else begin
            r_ce <= ChipEnable;
            r_pc <= bus.branch_flag_i ? bus.branch_target_i & ~ADDR_W'(7) :
                    w_fire ? r_pc + ADDR_W'(PC_STEP) : r_pc;
        end
    end
    assign bus.rom_ce_o = r_ce;
    assign bus.rom_addr_o = r_pc;
    assign bus.id_valid_o = w_valid;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plus random stimulus with a program-order scoreboard
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int n_pops = 0;
    logic [63:0] inst_mem [64];
    logic [31:0] exp_q [$];
    bit hold;
    logic [31:0] hold_pc;
    logic [63:0] hold_inst;

    always #5 clk = ~clk;

    inst_fetch_if bus ();
    inst_fetch_if wbus ();
    inst_fetch u_dut (.clk(clk), .rst(rst), .bus(bus));
    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (.clk(clk), .rst(rst), .bus(wbus));

    assign bus.rom_inst_i = inst_mem[bus.rom_addr_o[8:3]];
    assign wbus.rom_inst_i = {32'hC0DE_0000, wbus.rom_addr_o};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decode must see a sequential program-order stream starting at the latest reset/redirect.
    function automatic void restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 3000; i++) exp_q.push_back(start + 32'(8 * i));
    endfunction

    always @(posedge clk) begin
        if (rst) restart(32'h0);
        else if (bus.branch_flag_i) restart({bus.branch_target_i[31:3], 3'b000});
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (hold) begin
            check("head_stable_valid", 64'(bus.id_valid_o), 64'd1);
            check("head_stable_pc", 64'(bus.id_pc_o), 64'(hold_pc));
            check("head_stable_inst", bus.id_inst_o, hold_inst);
        end
        if (bus.id_valid_o === 1'b1 && bus.id_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", 64'(bus.id_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", 64'(bus.id_pc_o), 64'(e));
                check("sb_inst", bus.id_inst_o, inst_mem[e[8:3]]);
                n_pops++;
            end
        end
        hold = (bus.id_valid_o === 1'b1) && !bus.id_ready_i && !bus.branch_flag_i && !rst;
        hold_pc = bus.id_pc_o;
        hold_inst = bus.id_inst_o;
    end

    initial begin
        for (int i = 0; i < 64; i++) inst_mem[i] = {$urandom, $urandom};
        bus.id_ready_i = 1'b1;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = '0;
        wbus.id_ready_i = 1'b1;
        wbus.branch_flag_i = 1'b0;
        wbus.branch_target_i = '0;
        step();
        step();
        check("rst_valid", 64'(bus.id_valid_o), 64'd0);
        check("rst_ce", 64'(bus.rom_ce_o), 64'd0);
        check("rst_addr", 64'(bus.rom_addr_o), 64'd0);
        check("wrap_rst_addr", 64'(wbus.rom_addr_o), 64'hFFFF_FFF8);
        rst = 1'b0;
        step();
        check("ce_after_release", 64'(bus.rom_ce_o), 64'd1);
        check("first_addr", 64'(bus.rom_addr_o), 64'd0);
        check("no_valid_yet", 64'(bus.id_valid_o), 64'd0);
        step();
        check("first_valid", 64'(bus.id_valid_o), 64'd1);
        check("first_pc", 64'(bus.id_pc_o), 64'd0);
        check("first_inst", bus.id_inst_o, inst_mem[0]);
        check("second_addr", 64'(bus.rom_addr_o), 64'h8);
        check("wrap_first_pc", 64'(wbus.id_pc_o), 64'hFFFF_FFF8);
        check("wrap_first_inst", wbus.id_inst_o, 64'hC0DE_0000_FFFF_FFF8);
        for (int k = 0; k < 4; k++) begin
            step();
            check("stream_addr", 64'(bus.rom_addr_o), 64'(16 + 8 * k));
            check("stream_pc", 64'(bus.id_pc_o), 64'(8 + 8 * k));
            if (k == 0) check("wrap_second_pc", 64'(wbus.id_pc_o), 64'h0);
        end
        bus.id_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("bp_valid", 64'(bus.id_valid_o), 64'd1);
        check("bp_head_pc", 64'(bus.id_pc_o), 64'h20);
        check("bp_addr_frozen", 64'(bus.rom_addr_o), 64'h30);
        bus.id_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) step();
        bus.id_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) step();
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h2B;
        step();
        bus.branch_flag_i = 1'b0;
        check("br_flush_valid", 64'(bus.id_valid_o), 64'd0);
        check("br_addr", 64'(bus.rom_addr_o), 64'h28);
        step();
        check("br_head_valid", 64'(bus.id_valid_o), 64'd1);
        check("br_head_pc", 64'(bus.id_pc_o), 64'h28);
        check("br_head_inst", bus.id_inst_o, inst_mem[5]);
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h10;
        step();
        bus.branch_flag_i = 1'b0;
        step();
        step();
        check("pre_pop_pc", 64'(bus.id_pc_o), 64'h10);
        bus.id_ready_i = 1'b1;
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h40;
        check("br_pop_valid", 64'(bus.id_valid_o), 64'd1);
        step();
        bus.branch_flag_i = 1'b0;
        check("br_pop_flush", 64'(bus.id_valid_o), 64'd0);
        check("br_pop_addr", 64'(bus.rom_addr_o), 64'h40);
        step();
        check("br_pop_next_pc", 64'(bus.id_pc_o), 64'h40);
        bus.id_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        step();
        check("mid_rst_valid", 64'(bus.id_valid_o), 64'd0);
        check("mid_rst_ce", 64'(bus.rom_ce_o), 64'd0);
        rst = 1'b0;
        bus.id_ready_i = 1'b1;
        step();
        step();
        check("restart_valid", 64'(bus.id_valid_o), 64'd1);
        check("restart_pc", 64'(bus.id_pc_o), 64'd0);
        n_pops = 0;
        for (int k = 0; k < 2000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.id_ready_i = ($urandom_range(0, 3) != 0);
            bus.branch_flag_i = ($urandom_range(0, 19) == 0);
            bus.branch_target_i = $urandom;
            step();
        end
        rst = 1'b0;
        bus.branch_flag_i = 1'b0;
        step();
        check("random_progress", 64'(n_pops > 500), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch initiator; drives the instruction ROM's chip-enable and address, and captures the returned 64-bit instruction. It owns the PC and buffers fetched instructions in a small FIFO that feeds decode through a valid/ready handshake. Branch redirects from execute flush the buffer and reload the PC. The ROM returns data in the same cycle as the address (combinational read).

Parameters:
ADDR_W, 32, instruction address width (matches InstAddrBus)
INST_W, 64, instruction width (matches InstBus)
DEPTH, 2, fetch buffer entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset
PC_STEP, 8, byte increment per instruction (64-bit instructions)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
branch_flag_i  in  1  redirect request from execute
branch_target_i  in  ADDR_W  redirect byte address
rom_ce_o  out  1  ROM chip enable (ChipEnable/ChipDisable)
rom_addr_o  out  ADDR_W  ROM byte address; the ROM indexes by addr[..:3]
rom_inst_i  in  INST_W  ROM read data, valid in the same cycle
id_valid_o  out  1  buffer head valid toward decode
id_ready_i  in  1  decode accepts head
id_inst_o  out  INST_W  head instruction
id_pc_o  out  ADDR_W  head instruction's PC

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, rom_ce_o=0, buffer count=0, head/tail pointers=0, id_valid_o=0. id_inst_o and id_pc_o are don't-care while id_valid_o=0. Reset mid-stream discards all buffered entries.
- rom_ce_o is registered. It goes to 1 on the first posedge after rst deasserts and stays 1 until the next reset.
- rom_addr_o = pc register (combinational from the flop).
- pop = id_valid_o & id_ready_i.
- space = (count < DEPTH) | pop.
- fire = rom_ce_o & space & ~branch_flag_i.
- On fire: push {pc, rom_inst_i} at tail, then pc <= pc + PC_STEP. The PC wraps modulo 2^ADDR_W.
- If rom_ce_o=1 but space=0: the PC holds, nothing is pushed, and the ROM is re-read next cycle (the ROM has no side effects).
- Push and pop in the same cycle: count is unchanged, and both pointers advance modulo DEPTH.
- Branch (branch_flag_i=1 with rom_ce_o=1) has the highest priority:
  - count <= 0, pointers <= 0, no push.
  - pc <= {branch_target_i[ADDR_W-1:3], 3'b000}, because the low 3 bits are forced to zero.
  - A simultaneous pop is permitted: decode takes the current head that cycle. The rest of the buffer is discarded.
- branch_flag_i while rom_ce_o=0 (first cycle after reset): the PC is still loaded with the target, and the buffer stays empty.
- id_valid_o = (count != 0); id_inst_o/id_pc_o = head entry. These are registered-storage outputs, with no combinational path from rom_inst_i.
- Handshake rule: once id_valid_o=1, the head is stable until popped, reset or branch.
- Throughput: one instruction per cycle sustained when id_ready_i=1 every cycle.
- Latency: the first push happens on the 2nd posedge after reset deasserts, and id_valid_o=1 after that edge.
- Fill under stall: the buffer fills in DEPTH cycles, then fetching stalls.
- Overflow is impossible by construction. Underflow is impossible because pop requires valid.

Decomposition:
- The shared defines file holds InstAddrBus, InstBus, ChipEnable/ChipDisable and ZeroDoubleWord. It also gains PcStep (8) and ResetPc.
- One sub-module, fetch_buf: a synchronous FIFO of DEPTH entries with ADDR_W+INST_W bits each.
  - Inputs: push, pop, flush.
  - Outputs: count, head data.
  - Flush has priority over push and is applied after pop.
- inst_fetch holds the PC/ce logic and instantiates fetch_buf.

Test Plan:
- Reset then release, ROM model preloaded with 9 words, id_ready_i=1:
  - rom_ce_o=1 one cycle after release.
  - rom_addr_o steps 0x0, 0x8, 0x10, …
  - Decode sees inst_mem[0] with pc 0x0 on the 2nd cycle after release, then one word per cycle in order.
- Backpressure: hold id_ready_i=0 for 5 cycles from steady state.
  - Buffer fills to 2, and rom_addr_o freezes at head pc+0x10.
  - On release, decode resumes with no lost or duplicated instruction.
- Branch with a full buffer: branch_flag_i=1, target=0x2B.
  - Next cycle, id_valid_o=0 and rom_addr_o=0x28.
  - The following cycle, the head pc is 0x28 with inst_mem[5].
- Branch with a simultaneous pop: id_ready_i=1, head pc 0x10.
  - Decode receives 0x10 that cycle.
  - The next valid head is the branch target. Entry 0x18 is never presented.
- Wrap: RESET_PC=0xFFFFFFF8 (ADDR_W=32) with a stub ROM; fetched PCs go 0xFFFFFFF8 then 0x0.
- Reset asserted mid-stream with 2 entries buffered:
  - id_valid_o=0 and rom_ce_o=0 after the edge.
  - Restart fetches from RESET_PC.
